// File: rtl/alu_pkg.sv
// Shared ALUOp encodings, FSM state encoding and default datapath width for alu_iter.
package alu_pkg;

  localparam int unsigned DEFAULT_WIDTH = 64;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: shift-add multiplier and restoring divider on one register set.
// MUL: {acc,lo} starts as {0,b}, m=a; each step adds m when lo[0] and shifts right.
// DIV: {acc,lo} starts as {0,a}, m=b; each step shifts left and subtracts m when it fits.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             div_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_c,
  output logic [WIDTH-1:0] lo_c,
  output logic [WIDTH-1:0] acc_c
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   mac;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   trial;

  // Next-state for the shared accumulator / shifted operand / counter.
  always_comb begin
    acc_d = acc_q;
    lo_d  = lo_q;
    m_d   = m_q;
    cnt_d = cnt_q;
    div_d = div_q;
    sum   = {1'b0, acc_q} + {1'b0, m_q};
    mac   = lo_q[0] ? sum : {1'b0, acc_q};
    shl   = {acc_q, lo_q[WIDTH-1]};
    trial = shl - {1'b0, m_q};
    if (start) begin
      acc_d = '0;
      lo_d  = div_mode ? a : b;
      m_d   = div_mode ? b : a;
      cnt_d = '0;
      div_d = div_mode;
    end else if (step) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        // Borrow in the top bit means the divisor did not fit: restore.
        if (!trial[WIDTH]) begin
          acc_d = trial[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shl[WIDTH-1:0];
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = mac[WIDTH:1];
        lo_d  = {mac[0], lo_q[WIDTH-1:1]};
      end
    end
    last_c = step && (cnt_q == CW'(WIDTH - 1));
    lo_c   = lo_d;
    acc_c  = acc_d;
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      lo_q  <= '0;
      m_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      lo_q  <= lo_d;
      m_q   <= m_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIVU/REMU.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             LessThan,
  output logic             LessThanS,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             lt_q, lt_d;
  logic             lts_q, lts_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] single_c;
  logic             lts_c;
  logic [SHW-1:0]   shamt;
  logic             md_start;
  logic             md_step;
  logic             md_div;
  logic             md_last_c;
  logic [WIDTH-1:0] md_lo_c;
  logic [WIDTH-1:0] md_acc_c;

  assign lts_c   = $signed(a) < $signed(b);
  assign shamt   = b[SHW-1:0];
  assign md_div  = (ALUOp != OP_MUL);
  assign md_step = ((state_q == ST_MUL) || (state_q == ST_DIV)) && !flush;

  // Single-cycle result from the live operands; only used on the accept cycle.
  always_comb begin
    single_c = '0;
    case (ALUOp)
      OP_AND:  single_c = a & b;
      OP_OR:   single_c = a | b;
      OP_ADD:  single_c = a + b;
      OP_SUB:  single_c = a - b;
      OP_NOR:  single_c = ~(a | b);
      OP_SLL:  single_c = a << shamt;
      OP_SRL:  single_c = a >> shamt;
      OP_SRA:  single_c = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  single_c = WIDTH'(lts_c);
      default: single_c = '0;
    endcase
  end

  // FSM next-state, result/flag capture and registered handshake decodes.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    lts_d    = lts_q;
    md_start = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            op_d   = ALUOp;
            zero_d = (a == b);
            lt_d   = (a < b);
            lts_d  = lts_c;
            if (ALUOp == OP_MUL) begin
              state_d  = ST_MUL;
              md_start = 1'b1;
            end else if ((ALUOp == OP_DIVU) || (ALUOp == OP_REMU)) begin
              state_d  = ST_DIV;
              md_start = 1'b1;
            end else begin
              result_d = single_c;
              state_d  = ST_DONE;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (md_last_c) begin
            result_d = (op_q == OP_REMU) ? md_acc_c : md_lo_c;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d == ST_MUL) || (state_d == ST_DIV);
  end

  // Control and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_AND;
      result_q    <= '0;
      zero_q      <= 1'b0;
      lt_q        <= 1'b0;
      lts_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      lt_q        <= lt_d;
      lts_q       <= lts_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .start    (md_start),
    .div_mode (md_div),
    .step     (md_step),
    .a        (a),
    .b        (b),
    .last_c   (md_last_c),
    .lo_c     (md_lo_c),
    .acc_c    (md_acc_c)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign LessThan  = lt_q;
  assign LessThanS = lts_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=64.
module tb_alu_iter;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        less_than;
  logic        less_than_s;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  alu_iter #(.WIDTH(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUOp     (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .Zero      (zero),
    .LessThan  (less_than),
    .LessThanS (less_than_s),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present one op for one accept edge, then scramble the inputs.
  task automatic issue(input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
    @(negedge clk);
    check_b("in_ready_before_issue", in_ready, 1'b1);
    alu_op   = op;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    alu_op   = 4'($urandom);
  endtask

  // Latency counted so a result offered at the edge right after accept counts as 1.
  task automatic wait_done(output int lat, output bit rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp, input int exp_lat);
    int lat;
    bit rdy_seen;
    issue(op, av, bv);
    wait_done(lat, rdy_seen);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_b({tag, "_in_ready_low_while_busy"}, rdy_seen, 1'b0);
    check({tag, "_result"}, result, exp);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_b("out_valid_after_take", out_valid, 1'b0);
    check_b("in_ready_after_take", in_ready, 1'b1);
  endtask

  initial begin
    int ov_seen;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    alu_op    = OP_AND;
    repeat (3) @(negedge clk);
    check("rst_result", result, 64'h0);
    check_b("rst_out_valid", out_valid, 1'b0);
    check_b("rst_busy", busy, 1'b0);
    check_b("rst_zero", zero, 1'b0);
    check_b("rst_lt", less_than, 1'b0);
    check_b("rst_lts", less_than_s, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_b("rst_in_ready", in_ready, 1'b1);

    run_op("and", OP_AND, 64'hF0F0, 64'hFF00, 64'hF000, 1);
    take();

    // Reset in the middle of a multiply.
    issue(OP_MUL, 64'd3, 64'd5);
    check_b("mul_busy", busy, 1'b1);
    repeat (9) @(negedge clk);
    check_b("mul_mid_in_ready", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_b("rstmid_out_valid", out_valid, 1'b0);
    check("rstmid_result", result, 64'h0);
    check_b("rstmid_busy", busy, 1'b0);
    check_b("rstmid_lt", less_than, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_b("rstmid_in_ready", in_ready, 1'b1);
    run_op("add_5_7", OP_ADD, 64'd5, 64'd7, 64'd12, 1);
    take();

    run_op("add_wrap", OP_ADD, ONES, 64'd1, 64'h0, 1);
    check_b("add_wrap_zero", zero, 1'b0);
    check_b("add_wrap_lt", less_than, 1'b0);
    check_b("add_wrap_lts", less_than_s, 1'b1);
    take();

    run_op("sub_3_3", OP_SUB, 64'd3, 64'd3, 64'h0, 1);
    check_b("sub_3_3_zero", zero, 1'b1);
    check_b("sub_3_3_lt", less_than, 1'b0);
    take();
    run_op("sub_0_1", OP_SUB, 64'd0, 64'd1, ONES, 1);
    check_b("sub_0_1_lt", less_than, 1'b1);
    take();

    run_op("slt_m1_1", OP_SLT, ONES, 64'd1, 64'd1, 1);
    take();
    run_op("slt_1_m1", OP_SLT, 64'd1, ONES, 64'd0, 1);
    check_b("slt_1_m1_lt", less_than, 1'b1);
    check_b("slt_1_m1_lts", less_than_s, 1'b0);
    take();

    run_op("sra", OP_SRA, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1);
    take();
    run_op("sll_64", OP_SLL, 64'h1234, 64'd64, 64'h1234, 1);
    take();
    run_op("sll_4", OP_SLL, 64'h1234, 64'd4, 64'h12340, 1);
    take();
    run_op("srl", OP_SRL, 64'h8000_0000_0000_00F0, 64'h104, 64'h0800_0000_0000_000F, 1);
    take();
    run_op("nor", OP_NOR, 64'h0F, 64'hF0, 64'hFFFF_FFFF_FFFF_FF00, 1);
    take();
    run_op("bad_op", 4'b1111, 64'd5, 64'd3, 64'h0, 1);
    take();

    run_op("mul", OP_MUL, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001, 65);
    take();
    run_op("mul_ones_3", OP_MUL, ONES, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    take();

    run_op("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    // Consumer stalls for 10 cycles: result must hold and no new op accepted.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_result", result, 64'd14);
      check_b("stall_out_valid", out_valid, 1'b1);
      check_b("stall_in_ready", in_ready, 1'b0);
    end
    take();
    run_op("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    take();
    run_op("divu_by0", OP_DIVU, 64'd12345, 64'd0, ONES, 65);
    take();
    run_op("divu_big", OP_DIVU, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    take();
    run_op("remu_big", OP_REMU, ONES, 64'h10, 64'hF, 65);
    take();
    run_op("remu_9_0", OP_REMU, 64'd9, 64'd0, 64'd9, 65);
    take();

    // Flush on cycle 30 of a divide.
    issue(OP_DIVU, 64'd1000, 64'd3);
    repeat (29) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_b("flush_in_ready", in_ready, 1'b1);
    check_b("flush_busy", busy, 1'b0);
    ov_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) ov_seen++;
      @(negedge clk);
    end
    check("flush_no_out_valid", 64'(ov_seen), 64'd0);
    check("flush_result_kept", result, 64'd9);

    // Flush wins over out_ready in DONE.
    run_op("or", OP_OR, 64'hF0, 64'h0F, 64'hFF, 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    out_ready = 1'b0;
    check_b("flush_done_out_valid", out_valid, 1'b0);
    check_b("flush_done_in_ready", in_ready, 1'b1);

    // Flush wins over an accept in IDLE.
    alu_op   = OP_ADD;
    a        = 64'd1;
    b        = 64'd1;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_b("flush_accept_out_valid", out_valid, 1'b0);
    check_b("flush_accept_in_ready", in_ready, 1'b1);
    check_b("flush_accept_zero", zero, 1'b0);

    run_op("add_after_flush", OP_ADD, 64'd40, 64'd2, 64'd42, 1);
    take();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
